// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, op classification
// helpers and the scheduler state encoding.
package alu_pkg;

    localparam logic [5:0] OP_AND = 6'b000000;
    localparam logic [5:0] OP_OR  = 6'b000001;
    localparam logic [5:0] OP_XOR = 6'b000010;
    localparam logic [5:0] OP_SLL = 6'b000110;
    localparam logic [5:0] OP_SRA = 6'b000100;
    localparam logic [5:0] OP_SRL = 6'b000101;
    localparam logic [5:0] OP_SNE = 6'b110001;
    localparam logic [5:0] OP_SLT = 6'b110010;
    localparam logic [5:0] OP_SGT = 6'b110011;
    localparam logic [5:0] OP_SLE = 6'b110100;
    localparam logic [5:0] OP_SGE = 6'b110110;
    localparam logic [5:0] OP_SUB = 6'b111000;
    localparam logic [5:0] OP_ADD = 6'b100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRA, OP_SRL,
            OP_SNE, OP_SLT, OP_SGT,
            OP_SLE, OP_SGE,
            OP_SUB, OP_ADD: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [5:0] op);
        return (op == OP_SLL) || (op == OP_SRA) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with a one-bit priority pointer.
// Ports: req_i (valids), advance_i/last_i (served index), gnt_o (one-hot).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // Pointer names the requester that wins a tie.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = ~last_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE/EXEC/RESP).
// Ports: req0/1 valid-ready ops, rsp0/1 results, alu_* to the ALU, busy.
// Optional ALU_ARB_STATS_EN adds stat_grant0/stat_grant1 accept counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STAT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [5:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [5:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic             alu_sel0,
    output logic             alu_sel1,
    output logic             alu_sel2,
    output logic             alu_sel3,
    output logic             alu_sel4,
    output logic             alu_sel5,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_grant0,
    output logic [STAT_W-1:0] stat_grant1
`endif
);

    state_e           state_q, state_d;
    logic             idx_q, idx_d;
    logic [5:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic [1:0]       gnt;
    logic             gidx;
    logic             acc;
    logic             rsp_hs;
    logic             adv;
    logic [5:0]       op_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     ({req1_valid, req0_valid}),
        .advance_i (adv),
        .last_i    (idx_q),
        .gnt_o     (gnt)
    );

    assign gidx  = gnt[1];
    assign op_in = gidx ? req1_op : req0_op;
    assign a_in  = gidx ? req1_a  : req0_a;
    assign b_in  = gidx ? req1_b  : req0_b;
    assign acc   = (state_q == IDLE) && (gnt != 2'b00);

    // Ready is held low while reset is asserted even if a valid is up.
    assign req0_ready = rst_n && (state_q == IDLE) && gnt[0];
    assign req1_ready = rst_n && (state_q == IDLE) && gnt[1];

    assign rsp_hs = (state_q == RESP)
                 && (idx_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    idx_d = gidx;
                    if (is_legal(op_in)) begin
                        op_d  = op_in;
                        a_d   = a_in;
                        b_d   = b_in;
                        // Shift amount only uses the low bits of b.
                        if (is_shift(op_in)) begin
                            b_d[WIDTH-1:SHAMT_W] = '0;
                        end
                        err_d   = 1'b0;
                        state_d = EXEC;
                    end else begin
                        // ALU registers untouched: no ALU activity.
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                res_d   = alu_out;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    adv     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign rsp0_valid = (state_q == RESP) && !idx_q;
    assign rsp1_valid = (state_q == RESP) &&  idx_q;
    assign rsp0_data  = rsp0_valid ? res_q : '0;
    assign rsp1_data  = rsp1_valid ? res_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

    assign alu_in1  = a_q;
    assign alu_in2  = b_q;
    assign alu_sel0 = op_q[0];
    assign alu_sel1 = op_q[1];
    assign alu_sel2 = op_q[2];
    assign alu_sel3 = op_q[3];
    assign alu_sel4 = op_q[4];
    assign alu_sel5 = op_q[5];

    assign busy = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] cnt0_q, cnt0_d;
    logic [STAT_W-1:0] cnt1_q, cnt1_d;

    // Counters wrap naturally at 2^STAT_W.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (acc && !gidx) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (acc && gidx) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign stat_grant0 = cnt0_q;
    assign stat_grant1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU model
// attached to the alu_* ports.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [5:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0;
    logic [W-1:0] req1_a = '0, req1_b = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic         rsp0_err, rsp1_err;
    logic [W-1:0] alu_in1, alu_in2, alu_out;
    logic         alu_sel0, alu_sel1, alu_sel2;
    logic         alu_sel3, alu_sel4, alu_sel5;
    logic         busy;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]  stat_grant0, stat_grant1;
`endif

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_sel0   (alu_sel0),
        .alu_sel1   (alu_sel1),
        .alu_sel2   (alu_sel2),
        .alu_sel3   (alu_sel3),
        .alu_sel4   (alu_sel4),
        .alu_sel5   (alu_sel5),
        .alu_out    (alu_out),
        .busy       (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic         idx;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // External ALU: shifts use the full in2, so unmasked b shows up.
    function automatic logic [W-1:0] alu_fn(input logic [5:0] op,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (op)
            6'b000000: return x & y;
            6'b000001: return x | y;
            6'b000010: return x ^ y;
            6'b000110: return x << y;
            6'b000100: return $unsigned($signed(x) >>> y);
            6'b000101: return x >> y;
            6'b110001: return {31'd0, x != y};
            6'b110010: return {31'd0, $signed(x) <  $signed(y)};
            6'b110011: return {31'd0, $signed(x) >  $signed(y)};
            6'b110100: return {31'd0, $signed(x) <= $signed(y)};
            6'b110110: return {31'd0, $signed(x) >= $signed(y)};
            6'b111000: return x - y;
            6'b100000: return x + y;
            default:   return 32'hDEADBEEF;
        endcase
    endfunction

    assign alu_out = alu_fn({alu_sel5, alu_sel4, alu_sel3,
                             alu_sel2, alu_sel1, alu_sel0},
                            alu_in1, alu_in2);

    logic [5:0] legal_ops [13] = '{
        6'b000000, 6'b000001, 6'b000010, 6'b000110, 6'b000100,
        6'b000101, 6'b110001, 6'b110010, 6'b110011, 6'b110100,
        6'b110110, 6'b111000, 6'b100000
    };

    function automatic logic legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t expect_of(input logic n,
                                       input logic [5:0] op,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        exp_t e;
        logic [W-1:0] bb;
        e.idx = n;
        bb = b;
        if (op == 6'b000110 || op == 6'b000100 || op == 6'b000101)
            bb = b & 32'h1F;
        if (legal(op)) begin
            e.data = alu_fn(op, a, bb);
            e.err  = 1'b0;
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    task automatic rsp_pop(input logic n,
                           input logic [W-1:0] d,
                           input logic err);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_rsp", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("rsp_idx", n, e.idx);
            check("rsp_data", d, e.data);
            check("rsp_err", err, e.err);
        end
    endtask

    // Handshake seen at negedge completes at the following posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp0_ready) rsp_pop(1'b0, rsp0_data, rsp0_err);
            if (rsp1_valid && rsp1_ready) rsp_pop(1'b1, rsp1_data, rsp1_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic n, input logic [5:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (n) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Wait for acceptance of requester n, push its expectation,
    // then drop valid right after the accepting edge.
    task automatic wait_acc(input logic n);
        int k;
        k = 0;
        @(negedge clk);
        while (!(n ? req1_ready : req0_ready) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            check(n ? "grant1_timeout" : "grant0_timeout", 1, 0);
        end else begin
            check("other_ready_low", n ? req0_ready : req1_ready, 0);
            if (n) sb_q.push_back(expect_of(1'b1, req1_op, req1_a, req1_b));
            else   sb_q.push_back(expect_of(1'b0, req0_op, req0_a, req0_b));
        end
        @(posedge clk);
        #1;
        if (n) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    // Count negedges after accept until rspN_valid.
    task automatic wait_rsp(input logic n, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check("busy_inflight", busy, 1);
        end while (!(n ? rsp1_valid : rsp0_valid) && lat < 40);
    endtask

    int lat;
    logic [W-1:0] s_in1, s_in2, s_d;
    logic [5:0]   s_op;
    logic [5:0]   r_op;
    logic         r_n;

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
        check("rst_data", {rsp0_data, rsp1_data}, 0);
        check("rst_alu_in", {alu_in1, alu_in2}, 0);
        check("rst_sel", {alu_sel5, alu_sel4, alu_sel3,
                          alu_sel2, alu_sel1, alu_sel0}, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        step();
        rst_n = 1'b1;
        step();

        // ADD on req0
        drive(1'b0, 6'b100000, 32'd5, 32'd7);
        wait_acc(1'b0);
        wait_rsp(1'b0, lat);
        check("add_lat", lat, 2);
        check("add_data", rsp0_data, 32'd12);
        check("add_err", rsp0_err, 0);
        @(negedge clk);
        check("add_idle", busy, 0);

        // SLL on req1 with masked shift amount
        step();
        drive(1'b1, 6'b000110, 32'd1, 32'hFFFFFFE3);
        wait_acc(1'b1);
        check("sll_in2", alu_in2, 32'd3);
        wait_rsp(1'b1, lat);
        check("sll_lat", lat, 2);
        check("sll_data", rsp1_data, 32'd8);

        // Contention: pointer back at req0
        step();
        drive(1'b0, 6'b000000, 32'hF0F0, 32'hFF00);
        drive(1'b1, 6'b000001, 32'h0F0F, 32'h00F0);
        wait_acc(1'b0);
        wait_rsp(1'b0, lat);
        check("cont_and", rsp0_data, 32'hF000);
        wait_acc(1'b1);
        drive(1'b1, 6'b000010, 32'h3, 32'h5);
        drive(1'b0, 6'b111000, 32'd9, 32'd4);
        wait_rsp(1'b1, lat);
        check("cont_or", rsp1_data, 32'h0FFF);
        wait_acc(1'b0);
        wait_rsp(1'b0, lat);
        wait_acc(1'b1);
        wait_rsp(1'b1, lat);

        // Illegal op leaves the ALU side untouched
        step();
        s_in1 = alu_in1;
        s_in2 = alu_in2;
        s_op  = {alu_sel5, alu_sel4, alu_sel3,
                 alu_sel2, alu_sel1, alu_sel0};
        drive(1'b0, 6'b111111, 32'h1234, 32'h5678);
        wait_acc(1'b0);
        wait_rsp(1'b0, lat);
        check("ill_lat", lat, 1);
        check("ill_err", rsp0_err, 1);
        check("ill_data", rsp0_data, 0);
        check("ill_in", {alu_in1, alu_in2}, {s_in1, s_in2});
        check("ill_sel", {alu_sel5, alu_sel4, alu_sel3,
                          alu_sel2, alu_sel1, alu_sel0}, s_op);

        // Backpressure on rsp0 with req1 waiting
        step();
        rsp0_ready = 1'b0;
        drive(1'b0, 6'b000010, 32'hAAAA5555, 32'h0000FFFF);
        wait_acc(1'b0);
        drive(1'b1, 6'b000100, 32'h80000000, 32'd4);
        wait_rsp(1'b0, lat);
        s_d = rsp0_data;
        check("bp_data", s_d, 32'hAAAAAAAA);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", rsp0_valid, 1);
            check("bp_stable", rsp0_data, s_d);
            check("bp_req1_ready", req1_ready, 0);
        end
        step();
        rsp0_ready = 1'b1;
        wait_acc(1'b1);
        wait_rsp(1'b1, lat);
        check("sra_data", rsp1_data, 32'hF8000000);

        // Reset during EXEC
        step();
        drive(1'b0, 6'b100000, 32'd1, 32'd2);
        wait_acc(1'b0);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("mid_busy", busy, 0);
        check("mid_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
        check("mid_alu", {alu_in1, alu_in2}, 0);
        check("mid_sel", {alu_sel5, alu_sel4, alu_sel3,
                          alu_sel2, alu_sel1, alu_sel0}, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("mid_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        drive(1'b1, 6'b111000, 32'd10, 32'd3);
        wait_acc(1'b1);
        wait_rsp(1'b1, lat);
        check("sub_data", rsp1_data, 32'd7);

        // Random mix through the scoreboard
        for (int i = 0; i < 16; i++) begin
            step();
            r_n  = 1'($urandom_range(0, 1));
            r_op = ($urandom_range(0, 5) == 0) ? 6'b101010
                 : legal_ops[$urandom_range(0, 12)];
            drive(r_n, r_op, $urandom, $urandom);
            wait_acc(r_n);
            wait_rsp(r_n, lat);
            check("rnd_lat", lat, legal(r_op) ? 2 : 1);
        end

        step();
        step();
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
